// File: rtl/fib_pkg.sv
// Shared state encoding, default widths and a width helper for the Fibonacci host controller.
package fib_pkg;

   localparam int N_W_DEF   = 6;
   localparam int RES_W_DEF = 32;
   localparam int DEPTH_DEF = 4;
   localparam int TMO_DEF   = 64;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_RUN,
      S_STOP,
      S_DLVR
   } host_state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fib_cmd_fifo.sv
// Command FIFO holding pending Fibonacci indices, DEPTH entries of W bits.
// Latency: a push is visible at the head one cycle later; the head is read combinationally.
// Backpressure: full blocks pushes (no overwrite); pop on empty is ignored.
module fib_cmd_fifo
   import fib_pkg::*;
#(
   parameter int W     = N_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic         CLK,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] pop_dat,
   output logic         full,
   output logic         empty
);
   localparam int AW = cnt_w(DEPTH);

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];
   logic         do_push;
   logic         do_pop;

   // Extra pointer bit tells full from empty when the index bits match.
   always_comb begin
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      empty    = (wr_ptr_q == rd_ptr_q);
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      end
      pop_dat  = mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/fib_host_ctrl.sv
// Requester-side controller: queues indices, runs one accelerator job at a time, returns results.
// Latency: command accept to res_vld is n+4 cycles minimum (idle accelerator, empty FIFO).
// Backpressure: cmd_rdy low when the FIFO is full; res_vld held with stable data until res_rdy.
module fib_host_ctrl
   import fib_pkg::*;
#(
   parameter int N_W   = N_W_DEF,
   parameter int RES_W = RES_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int TMO   = TMO_DEF
) (
   input  logic             CLK,
   input  logic             rst_n,
   input  logic             cmd_vld,
   output logic             cmd_rdy,
   input  logic [N_W-1:0]   cmd_n,
   output logic             acc_vld_in,
   input  logic             acc_rdy_in,
   output logic             acc_rdy_out,
   input  logic             acc_vld_out,
   input  logic [RES_W-1:0] acc_result,
   output logic             res_vld,
   input  logic             res_rdy,
   output logic [N_W-1:0]   res_n,
   output logic [RES_W-1:0] res_data,
   output logic             res_tmo,
   output logic             busy
);
   localparam int TW = cnt_w(TMO);

   host_state_t      state_q, state_d;
   logic [N_W-1:0]   job_n_q, job_n_d;
   logic [N_W-1:0]   step_cnt_q, step_cnt_d;
   logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic [RES_W-1:0] res_data_q, res_data_d;
   logic             res_tmo_q, res_tmo_d;
   logic             acc_vld_in_q, acc_vld_in_d;
   logic             acc_rdy_out_q, acc_rdy_out_d;
   logic             res_vld_q, res_vld_d;
   logic             proto_err_q, proto_err_d;

   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   logic [N_W-1:0]   fifo_head;

   fib_cmd_fifo #(
      .W     (N_W),
      .DEPTH (DEPTH)
   ) u_cmd_fifo (
      .CLK      (CLK),
      .rst_n    (rst_n),
      .push     (cmd_vld),
      .push_dat (cmd_n),
      .pop      (fifo_pop),
      .pop_dat  (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_comb begin
      state_d    = state_q;
      job_n_d    = job_n_q;
      step_cnt_d = step_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      res_data_d = res_data_q;
      res_tmo_d  = res_tmo_q;
      fifo_pop   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               job_n_d  = fifo_head;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (acc_rdy_in) begin
               step_cnt_d = job_n_q;
               state_d    = S_RUN;
            end
         end
         S_RUN: begin
            if (step_cnt_q == '0) begin
               tmo_cnt_d = '0;
               state_d   = S_STOP;
            end else begin
               step_cnt_d = step_cnt_q - N_W'(1);
            end
         end
         S_STOP: begin
            // A result arriving on the last timeout cycle still counts as a result.
            if (acc_vld_out) begin
               res_data_d = acc_result;
               res_tmo_d  = 1'b0;
               state_d    = S_DLVR;
            end else if (tmo_cnt_q == TW'(TMO - 1)) begin
               res_data_d = '0;
               res_tmo_d  = 1'b1;
               state_d    = S_DLVR;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
         end
         S_DLVR: begin
            if (res_rdy) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      acc_vld_in_d  = (state_d == S_ISSUE);
      acc_rdy_out_d = (state_d == S_STOP);
      res_vld_d     = (state_d == S_DLVR);
      proto_err_d   = proto_err_q | (acc_vld_out & (state_q != S_STOP));
   end

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         job_n_q       <= '0;
         step_cnt_q    <= '0;
         tmo_cnt_q     <= '0;
         res_data_q    <= '0;
         res_tmo_q     <= 1'b0;
         acc_vld_in_q  <= 1'b0;
         acc_rdy_out_q <= 1'b0;
         res_vld_q     <= 1'b0;
         proto_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         job_n_q       <= job_n_d;
         step_cnt_q    <= step_cnt_d;
         tmo_cnt_q     <= tmo_cnt_d;
         res_data_q    <= res_data_d;
         res_tmo_q     <= res_tmo_d;
         acc_vld_in_q  <= acc_vld_in_d;
         acc_rdy_out_q <= acc_rdy_out_d;
         res_vld_q     <= res_vld_d;
         proto_err_q   <= proto_err_d;
      end
   end

   assign cmd_rdy     = ~fifo_full;
   assign acc_vld_in  = acc_vld_in_q;
   assign acc_rdy_out = acc_rdy_out_q;
   assign res_vld     = res_vld_q;
   assign res_n       = job_n_q;
   assign res_data    = res_data_q;
   assign res_tmo     = res_tmo_q;
   assign busy        = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fib_host_ctrl.sv
// Bench for fib_host_ctrl: a behavioural accelerator that counts enabled steps and returns fib(steps-1),
// plus per-scenario tasks checking ordering, latency, timeout, stalls and reset against plain expectations.
module tb_fib_host_ctrl;
   localparam int N_W   = 6;
   localparam int RES_W = 32;
   localparam int DEPTH = 4;
   localparam int TMO   = 64;

   logic             CLK = 1'b0;
   logic             rst_n;
   logic             cmd_vld;
   logic             cmd_rdy;
   logic [N_W-1:0]   cmd_n;
   logic             acc_vld_in;
   logic             acc_rdy_in;
   logic             acc_rdy_out;
   logic             acc_vld_out;
   logic [RES_W-1:0] acc_result;
   logic             res_vld;
   logic             res_rdy;
   logic [N_W-1:0]   res_n;
   logic [RES_W-1:0] res_data;
   logic             res_tmo;
   logic             busy;

   int checks = 0;
   int errors = 0;

   int               acc_mode  = 0;   // 0: answer at once, 1: answer after acc_delay stop cycles, 2: never
   int               acc_delay = 0;
   logic             force_vld = 1'b0;
   logic             mdl_vld;
   logic [RES_W-1:0] mdl_res;
   int               exp_q[$];

   assign acc_vld_out = mdl_vld | force_vld;
   assign acc_result  = mdl_res;

   always #5 CLK = ~CLK;

   fib_host_ctrl #(
      .N_W   (N_W),
      .RES_W (RES_W),
      .DEPTH (DEPTH),
      .TMO   (TMO)
   ) dut (
      .CLK         (CLK),
      .rst_n       (rst_n),
      .cmd_vld     (cmd_vld),
      .cmd_rdy     (cmd_rdy),
      .cmd_n       (cmd_n),
      .acc_vld_in  (acc_vld_in),
      .acc_rdy_in  (acc_rdy_in),
      .acc_rdy_out (acc_rdy_out),
      .acc_vld_out (acc_vld_out),
      .acc_result  (acc_result),
      .res_vld     (res_vld),
      .res_rdy     (res_rdy),
      .res_n       (res_n),
      .res_data    (res_data),
      .res_tmo     (res_tmo),
      .busy        (busy)
   );

   function automatic logic [RES_W-1:0] fib(input int n);
      logic [RES_W-1:0] a, b, t;
      a = '0;
      b = 1;
      for (int i = 0; i < n; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Accelerator stand-in: counts cycles between job acceptance and the stop strobe.
   initial begin : acc_model
      int steps, wait_cnt;
      bit in_job, stopped, responded;
      mdl_vld = 1'b0;
      mdl_res = '0;
      steps = 0; wait_cnt = 0; in_job = 0; stopped = 0; responded = 0;
      forever begin
         @(negedge CLK);
         mdl_vld = 1'b0;
         if (rst_n !== 1'b1) begin
            in_job = 0;
         end else if (acc_vld_in === 1'b1 && acc_rdy_in === 1'b1) begin
            in_job = 1; stopped = 0; responded = 0; steps = 0; wait_cnt = 0;
         end else if (in_job && acc_rdy_out === 1'b1) begin
            stopped = 1;
            if (!responded && acc_mode != 2) begin
               if (acc_mode == 0 || wait_cnt >= acc_delay) begin
                  mdl_vld   = 1'b1;
                  mdl_res   = fib(steps - 1);
                  responded = 1;
               end else begin
                  wait_cnt++;
               end
            end
         end else if (in_job && !stopped) begin
            steps++;
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_cmd(input int n, input int budget, output bit ok);
      cmd_n   = N_W'(n);
      cmd_vld = 1'b1;
      ok      = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge CLK);
         if (cmd_rdy === 1'b1) ok = 1;
         tick();
      end
      cmd_vld = 1'b0;
      if (ok) exp_q.push_back(n);
   endtask

   task automatic wait_res(input int budget, output bit got, output int n,
                           output logic [RES_W-1:0] d, output logic t);
      got = 0; n = -1; d = '0; t = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge CLK);
         if (res_vld === 1'b1 && res_rdy === 1'b1) begin
            got = 1; n = int'(res_n); d = res_data; t = res_tmo;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      cmd_vld = 1'b1;
      cmd_n   = N_W'($urandom);
      res_rdy = 1'($urandom);
      repeat (3) tick();
      cmd_vld = 1'b0;
      rst_n   = 1'b1;
      @(negedge CLK);
      checks++; if (res_vld !== 1'b0)     begin errors++; $display("FAIL reset_res_vld got %b exp 0", res_vld); end
      checks++; if (acc_vld_in !== 1'b0)  begin errors++; $display("FAIL reset_acc_vld_in got %b exp 0", acc_vld_in); end
      checks++; if (acc_rdy_out !== 1'b0) begin errors++; $display("FAIL reset_acc_rdy_out got %b exp 0", acc_rdy_out); end
      checks++; if (cmd_rdy !== 1'b1)     begin errors++; $display("FAIL reset_cmd_rdy got %b exp 1", cmd_rdy); end
      checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (res_tmo !== 1'b0)     begin errors++; $display("FAIL reset_res_tmo got %b exp 0", res_tmo); end
      checks++; if (res_data !== '0)      begin errors++; $display("FAIL reset_res_data got %0d exp 0", res_data); end
      tick();
   endtask

   task automatic test_single();
      bit ok, got;
      int n, rn, k_rdy, k_res, stall;
      logic [RES_W-1:0] rd;
      logic rt;
      exp_q.delete();
      n = 10; acc_mode = 0; res_rdy = 1'b0;
      send_cmd(n, 10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_accept got 0 exp 1"); end
      k_rdy = -1; k_res = -1;
      for (int k = 1; k <= 200 && k_res < 0; k++) begin
         tick();
         if (acc_rdy_out === 1'b1 && k_rdy < 0) k_rdy = k;
         if (res_vld === 1'b1 && k_res < 0) k_res = k;
      end
      checks++; if (k_rdy != n + 3) begin errors++; $display("FAIL single_rdy_out_lat got %0d exp %0d", k_rdy, n + 3); end
      checks++; if (k_res != n + 4) begin errors++; $display("FAIL single_res_lat got %0d exp %0d", k_res, n + 4); end
      stall = $urandom_range(2, 5);
      for (int i = 0; i < stall; i++) begin
         tick();
         checks++;
         if (res_vld !== 1'b1 || res_data !== fib(n) || int'(res_n) != n) begin
            errors++; $display("FAIL single_stall vld %b data %0d n %0d exp 1 %0d %0d", res_vld, res_data, res_n, fib(n), n);
         end
      end
      res_rdy = 1'b1;
      wait_res(5, got, rn, rd, rt);
      checks++; if (!got)         begin errors++; $display("FAIL single_got got 0 exp 1"); end
      checks++; if (rn != n)      begin errors++; $display("FAIL single_res_n got %0d exp %0d", rn, n); end
      checks++; if (rd !== 55)    begin errors++; $display("FAIL single_res_data got %0d exp 55", rd); end
      checks++; if (rt !== 1'b0)  begin errors++; $display("FAIL single_res_tmo got %b exp 0", rt); end
      checks++; if (res_vld !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL single_after vld %b busy %b exp 0 0", res_vld, busy);
      end
   endtask

   task automatic test_random();
      bit ok, got;
      int n, rn;
      logic [RES_W-1:0] rd;
      logic rt;
      exp_q.delete();
      res_rdy = 1'b1;
      for (int j = 0; j < 8; j++) begin
         n = (j == 0) ? 0 : int'($urandom_range(0, 20));
         acc_mode  = int'($urandom_range(0, 1));
         acc_delay = int'($urandom_range(0, 10));
         send_cmd(n, 10, ok);
         wait_res(200, got, rn, rd, rt);
         checks++; if (!got)         begin errors++; $display("FAIL rand_got job %0d got 0 exp 1", j); end
         checks++; if (rn != n)      begin errors++; $display("FAIL rand_res_n job %0d got %0d exp %0d", j, rn, n); end
         checks++; if (rd !== fib(n)) begin errors++; $display("FAIL rand_res_data job %0d got %0d exp %0d", j, rd, fib(n)); end
         checks++; if (rt !== 1'b0)  begin errors++; $display("FAIL rand_res_tmo job %0d got %b exp 0", j, rt); end
      end
      acc_mode = 0;
   endtask

   task automatic test_back_to_back();
      bit ok, ok6;
      int accepted, n6;
      time t_acc, t_first;
      exp_q.delete();
      acc_mode = 0; res_rdy = 1'b0; accepted = 0;
      for (int i = 0; i < 1 + DEPTH; i++) begin
         send_cmd(int'($urandom_range(0, 8)), 4, ok);
         if (ok) accepted++;
      end
      @(negedge CLK);
      checks++; if (accepted != 1 + DEPTH) begin errors++; $display("FAIL b2b_accepted got %0d exp %0d", accepted, 1 + DEPTH); end
      checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL b2b_full_cmd_rdy got %b exp 0", cmd_rdy); end
      checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL b2b_busy got %b exp 1", busy); end
      tick();
      n6 = int'($urandom_range(0, 8));
      send_cmd(n6, 10, ok);
      checks++; if (ok) begin errors++; $display("FAIL b2b_overflow_accept got 1 exp 0"); end
      res_rdy = 1'b1;
      t_acc = 0; t_first = 0;
      fork
         begin
            send_cmd(n6, 300, ok6);
            t_acc = $time;
         end
         begin
            for (int j = 0; j < 2 + DEPTH; j++) begin
               bit got;
               int rn, en;
               logic [RES_W-1:0] rd;
               logic rt;
               wait_res(300, got, rn, rd, rt);
               if (j == 0) t_first = $time;
               en = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
               checks++;
               if (!got || rn != en || rd !== fib(en) || rt !== 1'b0) begin
                  errors++; $display("FAIL b2b_result %0d got v%0d n%0d d%0d t%b exp v1 n%0d d%0d t0", j, got, rn, rd, rt, en, fib(en));
               end
            end
         end
      join
      checks++; if (!ok6 || t_acc <= t_first) begin
         errors++; $display("FAIL b2b_late_accept ok %0d t_acc %0t t_first %0t exp accept after first result", ok6, t_acc, t_first);
      end
   endtask

   task automatic test_timeout();
      bit ok, got;
      int n1, n2, n3, rn, k_rdy, k_res;
      logic [RES_W-1:0] rd;
      logic rt;
      exp_q.delete();
      res_rdy = 1'b0; acc_mode = 2;
      n1 = int'($urandom_range(0, 8));
      n2 = int'($urandom_range(0, 8));
      send_cmd(n1, 10, ok);
      send_cmd(n2, 10, ok);
      k_rdy = -1; k_res = -1;
      for (int k = 1; k <= 300 && k_res < 0; k++) begin
         tick();
         if (acc_rdy_out === 1'b1 && k_rdy < 0) k_rdy = k;
         if (res_vld === 1'b1 && k_res < 0) k_res = k;
      end
      checks++; if (k_rdy < 0 || k_res - k_rdy != TMO) begin
         errors++; $display("FAIL tmo_latency got %0d exp %0d", k_res - k_rdy, TMO);
      end
      res_rdy = 1'b1;
      wait_res(5, got, rn, rd, rt);
      checks++; if (!got || rn != n1 || rd !== '0 || rt !== 1'b1) begin
         errors++; $display("FAIL tmo_result got v%0d n%0d d%0d t%b exp v1 n%0d d0 t1", got, rn, rd, rt, n1);
      end
      acc_mode = 0;
      wait_res(100, got, rn, rd, rt);
      checks++; if (!got || rn != n2 || rd !== fib(n2) || rt !== 1'b0) begin
         errors++; $display("FAIL tmo_next_job got v%0d n%0d d%0d t%b exp v1 n%0d d%0d t0", got, rn, rd, rt, n2, fib(n2));
      end
      // Answer on the final timeout cycle: result must win.
      acc_mode = 1; acc_delay = TMO - 1;
      n3 = int'($urandom_range(0, 8));
      send_cmd(n3, 10, ok);
      wait_res(300, got, rn, rd, rt);
      checks++; if (!got || rn != n3 || rd !== fib(n3) || rt !== 1'b0) begin
         errors++; $display("FAIL tmo_race got v%0d n%0d d%0d t%b exp v1 n%0d d%0d t0", got, rn, rd, rt, n3, fib(n3));
      end
      // Answer one cycle too late: timeout, late pulse ignored.
      acc_delay = TMO;
      send_cmd(n3, 10, ok);
      wait_res(300, got, rn, rd, rt);
      checks++; if (!got || rn != n3 || rd !== '0 || rt !== 1'b1) begin
         errors++; $display("FAIL tmo_late got v%0d n%0d d%0d t%b exp v1 n%0d d0 t1", got, rn, rd, rt, n3);
      end
      acc_mode = 0;
      repeat (3) tick();
   endtask

   task automatic test_rdy_in_stall();
      bit ok, got;
      int n, rn, held, k_rdy;
      logic [RES_W-1:0] rd;
      logic rt;
      exp_q.delete();
      acc_mode = 0; res_rdy = 1'b1; acc_rdy_in = 1'b0;
      n = int'($urandom_range(0, 10));
      send_cmd(n, 10, ok);
      for (int i = 0; i < 10 && acc_vld_in !== 1'b1; i++) tick();
      held = 0;
      for (int c = 0; c < 7; c++) begin
         if (acc_vld_in === 1'b1 && acc_rdy_out === 1'b0) held++;
         tick();
      end
      checks++; if (held != 7) begin errors++; $display("FAIL stall_vld_in_held got %0d exp 7", held); end
      checks++; if (acc_vld_in !== 1'b1) begin errors++; $display("FAIL stall_vld_in_still got %b exp 1", acc_vld_in); end
      acc_rdy_in = 1'b1;
      k_rdy = -1;
      for (int k = 1; k <= 100 && k_rdy < 0; k++) begin
         tick();
         if (k == 1) begin
            checks++; if (acc_vld_in !== 1'b0) begin errors++; $display("FAIL stall_vld_in_drop got %b exp 0", acc_vld_in); end
         end
         if (acc_rdy_out === 1'b1) k_rdy = k;
      end
      checks++; if (k_rdy != n + 2) begin errors++; $display("FAIL stall_rdy_out_lat got %0d exp %0d", k_rdy, n + 2); end
      wait_res(10, got, rn, rd, rt);
      checks++; if (!got || rn != n || rd !== fib(n) || rt !== 1'b0) begin
         errors++; $display("FAIL stall_result got v%0d n%0d d%0d t%b exp v1 n%0d d%0d t0", got, rn, rd, rt, n, fib(n));
      end
   endtask

   task automatic test_reset_mid();
      bit ok, got, seen;
      int n, rn;
      logic [RES_W-1:0] rd;
      logic rt;
      exp_q.delete();
      acc_mode = 2; res_rdy = 1'b1;
      for (int i = 0; i < 3; i++) send_cmd(int'($urandom_range(0, 6)), 10, ok);
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         tick();
         if (acc_rdy_out === 1'b1) seen = 1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL rstmid_reach_stop got 0 exp 1"); end
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      exp_q.delete();
      @(negedge CLK);
      checks++; if (busy !== 1'b0 || cmd_rdy !== 1'b1 || res_vld !== 1'b0 || acc_rdy_out !== 1'b0 || acc_vld_in !== 1'b0) begin
         errors++; $display("FAIL rstmid_state busy %b cmd_rdy %b res_vld %b rdy_out %b vld_in %b exp 0 1 0 0 0",
                            busy, cmd_rdy, res_vld, acc_rdy_out, acc_vld_in);
      end
      tick();
      force_vld = 1'b1;
      tick();
      force_vld = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (res_vld !== 1'b0 || busy !== 1'b0 || acc_vld_in !== 1'b0) seen = 1;
      end
      tick();
      checks++; if (seen) begin errors++; $display("FAIL rstmid_stale_pulse got activity exp idle"); end
      acc_mode = 0;
      n = int'($urandom_range(0, 15));
      send_cmd(n, 10, ok);
      wait_res(100, got, rn, rd, rt);
      checks++; if (!got || rn != n || rd !== fib(n) || rt !== 1'b0) begin
         errors++; $display("FAIL rstmid_after got v%0d n%0d d%0d t%b exp v1 n%0d d%0d t0", got, rn, rd, rt, n, fib(n));
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      cmd_vld    = 1'b0;
      cmd_n      = '0;
      acc_rdy_in = 1'b1;
      res_rdy    = 1'b0;
      test_reset();
      test_single();
      test_random();
      test_back_to_back();
      test_timeout();
      test_rdy_in_stall();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
